// File: rtl/ad5541_update_sched.sv
`default_nettype none
// ============================================================================
//  Module      : ad5541_update_sched
//  Description : Paces 16-bit sample updates into the ad5541 serial DAC
//                driver. Streams samples through a small FIFO, lets a host
//                override write pre-empt the stream, and issues one dac_valid
//                pulse every max(div, MIN_GAP-1)+1 clocks.
//                Build option: AD5541_SCHED_MIDSCALE_UNDERRUN_EN makes an
//                underrun tick load MIDSCALE instead of repeating the last
//                sample.
//  Revision    : 1.0 - initial release
// ============================================================================
module ad5541_update_sched #(
    parameter int          DIV_WIDTH = 16,
    parameter int          FIFO_AW   = 4,
    parameter int          MIN_GAP   = 48,
    parameter logic [15:0] MIDSCALE  = 16'h8000
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 enable,
    input  logic [DIV_WIDTH-1:0] div,
    input  logic [15:0]          s_axis_tdata,
    input  logic                 s_axis_tvalid,
    output logic                 s_axis_tready,
    input  logic [15:0]          ovr_data,
    input  logic                 ovr_valid,
    output logic                 ovr_ready,
    output logic [15:0]          dac_data,
    output logic                 dac_valid,
    output logic [FIFO_AW:0]     fifo_level,
    output logic [15:0]          underrun_count
);

    localparam int                   c_DEPTH     = 1 << FIFO_AW;
    localparam logic [DIV_WIDTH-1:0] c_MIN_LIMIT = DIV_WIDTH'(MIN_GAP - 1);
    localparam logic [FIFO_AW:0]     c_FULL      = (FIFO_AW + 1)'(c_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_ISSUE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
    logic [DIV_WIDTH-1:0] limit_q, limit_d;
    logic [15:0]          dac_data_q, dac_data_d;
    logic [FIFO_AW:0]     level_q, level_d;
    logic [FIFO_AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [15:0]          under_q, under_d;
    logic                 ovr_taken_q, ovr_taken_d;
    logic [15:0]          ovr_tdata_q, ovr_tdata_d;
    logic [15:0]          mem_q [c_DEPTH];

    logic [DIV_WIDTH-1:0] w_limit_now;
    logic                 w_tick;
    logic                 w_ovr_elig;
    logic                 w_take_ovr;
    logic                 w_pop;
    logic                 w_under;
    logic                 w_push;

    // Period limit (P-1) is clamped so pulses never come faster than one driver frame.
    assign w_limit_now = (div > c_MIN_LIMIT) ? div : c_MIN_LIMIT;
    assign w_tick      = (state_q == ST_WAIT) && enable && (cnt_q == limit_q);
    // An override already taken stays ineligible until it drops or its data changes.
    assign w_ovr_elig  = ovr_valid && !(ovr_taken_q && (ovr_data == ovr_tdata_q));
    assign w_take_ovr  = w_tick && w_ovr_elig;
    assign w_pop       = w_tick && !w_ovr_elig && (level_q != '0);
    assign w_under     = w_tick && !w_ovr_elig && (level_q == '0);

    assign s_axis_tready  = enable && (state_q != ST_IDLE) && (level_q != c_FULL);
    assign w_push         = s_axis_tvalid && s_axis_tready;
    assign ovr_ready      = w_take_ovr;
    assign dac_valid      = (state_q == ST_ISSUE);
    assign dac_data       = dac_data_q;
    assign fifo_level     = level_q;
    assign underrun_count = under_q;

    // Scheduler FSM: period counter runs through ISSUE so pulses stay exactly P apart.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        limit_d = limit_q;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (enable) begin
                    state_d = ST_WAIT;
                    limit_d = w_limit_now;
                end
            end
            ST_WAIT: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (w_tick) begin
                    state_d = ST_ISSUE;
                    cnt_d   = '0;
                    limit_d = w_limit_now;
                end else begin
                    cnt_d = cnt_q + DIV_WIDTH'(1);
                end
            end
            ST_ISSUE: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    state_d = ST_WAIT;
                    cnt_d   = cnt_q + DIV_WIDTH'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Sample selection, FIFO bookkeeping, underrun counting and override tracking.
    always_comb begin
        dac_data_d  = dac_data_q;
        level_d     = level_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        under_d     = under_q;
        ovr_taken_d = ovr_taken_q;
        ovr_tdata_d = ovr_tdata_q;

        if (w_take_ovr) begin
            dac_data_d = ovr_data;
        end else if (w_pop) begin
            dac_data_d = mem_q[rd_ptr_q];
        end
`ifdef AD5541_SCHED_MIDSCALE_UNDERRUN_EN
        else if (w_under) begin
            dac_data_d = MIDSCALE;
        end
`endif

        if (w_under && (under_q != 16'hFFFF)) begin
            under_d = under_q + 16'd1;
        end

        if (w_take_ovr) begin
            ovr_taken_d = 1'b1;
            ovr_tdata_d = ovr_data;
        end else if (!ovr_valid) begin
            ovr_taken_d = 1'b0;
        end

        if (!enable) begin
            level_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (w_push) wr_ptr_d = wr_ptr_q + FIFO_AW'(1);
            if (w_pop)  rd_ptr_d = rd_ptr_q + FIFO_AW'(1);
            case ({w_push, w_pop})
                2'b10:   level_d = level_q + (FIFO_AW + 1)'(1);
                2'b01:   level_d = level_q - (FIFO_AW + 1)'(1);
                default: level_d = level_q;
            endcase
        end
    end

    // Control and datapath registers; reset aborts any pulse in flight.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            limit_q     <= c_MIN_LIMIT;
            dac_data_q  <= MIDSCALE;
            level_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            under_q     <= '0;
            ovr_taken_q <= 1'b0;
            ovr_tdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            limit_q     <= limit_d;
            dac_data_q  <= dac_data_d;
            level_q     <= level_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            under_q     <= under_d;
            ovr_taken_q <= ovr_taken_d;
            ovr_tdata_q <= ovr_tdata_d;
        end
    end

    // FIFO storage needs no reset; occupancy is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= s_axis_tdata;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ad5541_update_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ad5541_update_sched
//  Description : Self-checking bench for ad5541_update_sched. A schedule
//                model (absolute tick times, sample queue) predicts every
//                output each cycle; directed checks pin pulse timing and data.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ad5541_update_sched;

    logic        clk = 1'b0;
    logic        rstn;
    logic        enable;
    logic [15:0] div;
    logic [15:0] s_axis_tdata;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic [15:0] ovr_data;
    logic        ovr_valid;
    logic        ovr_ready;
    logic [15:0] dac_data;
    logic        dac_valid;
    logic [4:0]  fifo_level;
    logic [15:0] underrun_count;

    always #5 clk = ~clk;

    ad5541_update_sched dut (
        .clk            (clk),
        .rstn           (rstn),
        .enable         (enable),
        .div            (div),
        .s_axis_tdata   (s_axis_tdata),
        .s_axis_tvalid  (s_axis_tvalid),
        .s_axis_tready  (s_axis_tready),
        .ovr_data       (ovr_data),
        .ovr_valid      (ovr_valid),
        .ovr_ready      (ovr_ready),
        .dac_data       (dac_data),
        .dac_valid      (dac_valid),
        .fifo_level     (fifo_level),
        .underrun_count (underrun_count)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at edge", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Schedule model: a tick is due at an absolute edge number; the next
    // one is P edges later, P taken from div at the tick.
    // ------------------------------------------------------------------
    int          edge_no      = 0;
    bit          m_active     = 1'b0;
    int          m_next_tick  = 0;
    bit          m_valid      = 1'b0;
    bit          m_taken      = 1'b0;
    logic [15:0] m_taken_data = 16'h0;
    logic [15:0] m_data       = 16'h8000;
    logic [15:0] m_under      = 16'h0;
    logic [15:0] m_q [$];

    function automatic int eff_period(input logic [15:0] d);
        return (int'(d) > 47) ? int'(d) + 1 : 48;
    endfunction

    always @(posedge clk or negedge rstn) begin : model
        bit tick;
        bit elig;
        bit rdy;
        if (!rstn) begin
            m_active = 1'b0;
            m_valid  = 1'b0;
            m_taken  = 1'b0;
            m_data   = 16'h8000;
            m_under  = 16'h0;
            m_q.delete();
        end else begin
            edge_no++;
            rdy  = enable && m_active && (m_q.size() < 16);
            tick = m_active && enable && (edge_no == m_next_tick);
            elig = ovr_valid && !(m_taken && (ovr_data == m_taken_data));
            m_valid = tick;
            if (tick) begin
                m_next_tick = edge_no + eff_period(div);
                if (elig) begin
                    m_data       = ovr_data;
                    m_taken      = 1'b1;
                    m_taken_data = ovr_data;
                end else if (m_q.size() > 0) begin
                    m_data = m_q.pop_front();
                end else begin
                    if (m_under != 16'hFFFF) m_under = m_under + 16'd1;
`ifdef AD5541_SCHED_MIDSCALE_UNDERRUN_EN
                    m_data = 16'h8000;
`endif
                end
            end
            if (!(tick && elig) && !ovr_valid) m_taken = 1'b0;
            if (s_axis_tvalid && rdy) m_q.push_back(s_axis_tdata);
            if (!enable) begin
                m_q.delete();
                m_active = 1'b0;
            end else if (!m_active) begin
                m_active    = 1'b1;
                m_next_tick = edge_no + eff_period(div);
            end
        end
    end

    // Per-cycle comparison against the model plus pulse logging.
    int          p_time [$];
    logic [15:0] p_data [$];
    int          ovr_cnt = 0;

    always @(negedge clk) begin : compare
        bit exp_ovr;
        bit exp_rdy;
        exp_ovr = m_active && enable && (edge_no + 1 == m_next_tick) && ovr_valid
                  && !(m_taken && (ovr_data == m_taken_data));
        exp_rdy = enable && m_active && (m_q.size() < 16);
        check("dac_valid",      32'(dac_valid),      32'(m_valid));
        check("dac_data",       32'(dac_data),       32'(m_data));
        check("fifo_level",     32'(fifo_level),     32'(m_q.size()));
        check("underrun_count", 32'(underrun_count), 32'(m_under));
        check("s_axis_tready",  32'(s_axis_tready),  32'(exp_rdy));
        check("ovr_ready",      32'(ovr_ready),      32'(exp_ovr));
        if (dac_valid) begin
            p_time.push_back(edge_no);
            p_data.push_back(dac_data);
        end
        if (ovr_ready) ovr_cnt++;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_pulses(input int n, input int budget);
        int k;
        k = 0;
        while ((p_data.size() < n) && (k < budget)) begin
            @(negedge clk);
            #1;
            k++;
        end
        check("pulse_wait_timeout", 32'(p_data.size() >= n), 32'd1);
    endtask

    int          t_en;
    int          base;
    int          acc;
    int          o0;
    logic [15:0] exp_u;

    initial begin
`ifdef AD5541_SCHED_MIDSCALE_UNDERRUN_EN
        exp_u = 16'h8000;
`else
        exp_u = 16'h0004;
`endif
        rstn = 1'b0; enable = 1'b0; div = 16'd99;
        s_axis_tdata = 16'h0; s_axis_tvalid = 1'b0;
        ovr_data = 16'h0; ovr_valid = 1'b0;
        step(3);
        check("rst_dac_data",  32'(dac_data),       32'h8000);
        check("rst_dac_valid", 32'(dac_valid),      32'h0);
        check("rst_level",     32'(fifo_level),     32'h0);
        check("rst_underrun",  32'(underrun_count), 32'h0);
        check("rst_tready",    32'(s_axis_tready),  32'h0);
        rstn = 1'b1;
        step(2);

        // Four streamed samples at div=99
        t_en = edge_no + 1;
        enable = 1'b1;
        step(1);
        s_axis_tvalid = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            s_axis_tdata = 16'(i);
            step(1);
        end
        s_axis_tvalid = 1'b0;
        wait_pulses(4, 600);
        check("t1_first_latency", 32'(p_time[0] - t_en), 32'd100);
        for (int i = 0; i < 4; i++) check("t1_data", 32'(p_data[i]), 32'(i + 1));
        for (int i = 1; i < 4; i++) check("t1_gap", 32'(p_time[i] - p_time[i-1]), 32'd100);
        check("t1_underrun", 32'(underrun_count), 32'd0);

        // Three underrun ticks
        wait_pulses(7, 400);
        for (int i = 4; i < 7; i++) check("t3_data", 32'(p_data[i]), 32'(exp_u));
        check("t3_gap", 32'(p_time[6] - p_time[5]), 32'd100);
        check("t3_underrun", 32'(underrun_count), 32'd3);

        // div below the minimum gap
        step(1);
        enable = 1'b0;
        step(2);
        div = 16'd10;
        t_en = edge_no + 1;
        enable = 1'b1;
        wait_pulses(9, 200);
        check("t2_first_latency", 32'(p_time[7] - t_en), 32'd48);
        check("t2_gap", 32'(p_time[8] - p_time[7]), 32'd48);

        // Override beats a queued sample, held request taken only once
        step(1);
        enable = 1'b0;
        step(2);
        enable = 1'b1;
        step(1);
        s_axis_tvalid = 1'b1; s_axis_tdata = 16'h0010;
        step(1);
        s_axis_tvalid = 1'b0;
        ovr_data = 16'hABCD; ovr_valid = 1'b1;
        o0 = ovr_cnt;
        wait_pulses(10, 200);
        check("t4_ovr_data", 32'(p_data[9]), 32'hABCD);
        wait_pulses(11, 200);
        check("t4_next_data", 32'(p_data[10]), 32'h0010);
        check("t4_ovr_ready_cnt", 32'(ovr_cnt - o0), 32'd1);
        step(1);
        ovr_valid = 1'b0;

        // Overfill the FIFO with no ticks due, then drain it
        enable = 1'b0;
        div = 16'd999;
        step(2);
        enable = 1'b1;
        step(1);
        s_axis_tvalid = 1'b1;
        acc = 0;
        for (int i = 0; i < 20; i++) begin
            s_axis_tdata = 16'(16'h0100 + acc);
            if (s_axis_tready) acc++;
            step(1);
        end
        s_axis_tvalid = 1'b0;
        check("t5_accepted", 32'(acc), 32'd16);
        check("t5_level", 32'(fifo_level), 32'd16);
        check("t5_tready", 32'(s_axis_tready), 32'd0);
        div = 16'd10;
        base = p_data.size();
        wait_pulses(base + 16, 2200);
        for (int i = 0; i < 16; i++) check("t5_order", 32'(p_data[base + i]), 32'(16'h0100 + i));

        // Reset during the ISSUE cycle
        step(1);
        s_axis_tvalid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            s_axis_tdata = 16'(16'h0200 + i);
            step(1);
        end
        s_axis_tvalid = 1'b0;
        base = p_data.size();
        wait_pulses(base + 1, 200);
        check("t6_in_issue", 32'(dac_valid), 32'd1);
        check("t6_level_before", 32'(fifo_level), 32'd2);
        rstn = 1'b0;
        #1;
        check("t6_dac_valid", 32'(dac_valid),      32'd0);
        check("t6_dac_data",  32'(dac_data),       32'h8000);
        check("t6_level",     32'(fifo_level),     32'd0);
        check("t6_underrun",  32'(underrun_count), 32'd0);
        check("t6_tready",    32'(s_axis_tready),  32'd0);
        step(2);
        enable = 1'b0;
        rstn = 1'b1;
        step(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
